// File: rtl/jtframe_romrq_arb.sv
// Round-robin arbiter sharing one SDRAM read port among SLOTS romrq cache slots.
// One transaction at a time: grant, request/ack, data return with a one-hot fill strobe.
module jtframe_romrq_arb #(
    parameter int SLOTS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SLOTS-1:0]      slot_req,
    input  logic [22*SLOTS-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_we,
    output logic [31:0]           dout,
    output logic                  dout_ok,
    output logic                  sdram_req,
    output logic [21:0]           sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [31:0]           data_read
);

    localparam int SEL_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA, DONE} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic               sdram_req_q, sdram_req_d;
    logic [21:0]        sdram_addr_q, sdram_addr_d;
    logic [31:0]        dout_q, dout_d;
    logic               dout_ok_q, dout_ok_d;
    logic [SLOTS-1:0]   slot_we_q, slot_we_d;

    logic [21:0]        addr_arr [SLOTS];
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;
    logic               still_valid;

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_arr[i] = slot_addr[22*i +: 22];
        end
    end

    // Scan from farthest to nearest so the first requester after last_q wins.
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_s;
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_s      = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            idx   = (int'(last_q) + k) % SLOTS;
            idx_s = SEL_W'(idx);
            if (slot_req[idx_s]) begin
                pick_found = 1'b1;
                pick_idx   = idx_s;
            end
        end
    end

    // A word is only written into the cache if the slot still wants that same address.
    assign still_valid = slot_req[sel_q] && (addr_arr[sel_q] == sdram_addr_q);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_d       = last_q;
        sdram_req_d  = sdram_req_q;
        sdram_addr_d = sdram_addr_q;
        dout_d       = dout_q;
        dout_ok_d    = 1'b0;
        slot_we_d    = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d        = pick_idx;
                    last_d       = pick_idx;
                    sdram_addr_d = addr_arr[pick_idx];
                    sdram_req_d  = 1'b1;
                    state_d      = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    sdram_req_d = 1'b0;
                    if (data_rdy) begin
                        dout_d           = data_read;
                        dout_ok_d        = 1'b1;
                        slot_we_d[sel_q] = still_valid;
                        state_d          = DONE;
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (data_rdy) begin
                    dout_d           = data_read;
                    dout_ok_d        = 1'b1;
                    slot_we_d[sel_q] = still_valid;
                    state_d          = DONE;
                end
            end
            DONE: begin
                // Idle gap so the served slot can drop its request before the next scan.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_q       <= SEL_W'(SLOTS - 1);
            sdram_req_q  <= 1'b0;
            sdram_addr_q <= '0;
            dout_q       <= '0;
            dout_ok_q    <= 1'b0;
            slot_we_q    <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            sdram_req_q  <= sdram_req_d;
            sdram_addr_q <= sdram_addr_d;
            dout_q       <= dout_d;
            dout_ok_q    <= dout_ok_d;
            slot_we_q    <= slot_we_d;
        end
    end

    assign sdram_req  = sdram_req_q;
    assign sdram_addr = sdram_addr_q;
    assign dout       = dout_q;
    assign dout_ok    = dout_ok_q;
    assign slot_we    = slot_we_q;

endmodule

// File: tb/tb_jtframe_romrq_arb.sv
// Bench for jtframe_romrq_arb: 4-slot instance for function/corner cases, 8-slot instance for rotation.
module tb_jtframe_romrq_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-slot instance
    logic [3:0]  req;
    logic [21:0] a [4];
    logic [87:0] addr_flat;
    logic [3:0]  we;
    logic [31:0] dout;
    logic        dout_ok, sreq;
    logic [21:0] saddr;
    logic        ack, rdy;
    logic [31:0] rdata;

    assign addr_flat = {a[3], a[2], a[1], a[0]};

    jtframe_romrq_arb #(.SLOTS(4)) dut (
        .clk(clk), .rst(rst), .slot_req(req), .slot_addr(addr_flat),
        .slot_we(we), .dout(dout), .dout_ok(dout_ok), .sdram_req(sreq),
        .sdram_addr(saddr), .sdram_ack(ack), .data_rdy(rdy), .data_read(rdata)
    );

    // 8-slot instance
    logic [7:0]   req8;
    logic [175:0] addr8;
    logic [7:0]   we8;
    logic [31:0]  dout8;
    logic         dout_ok8, sreq8;
    logic [21:0]  saddr8;
    logic         ack8, rdy8;
    logic [31:0]  rdata8;

    jtframe_romrq_arb #(.SLOTS(8)) dut8 (
        .clk(clk), .rst(rst), .slot_req(req8), .slot_addr(addr8),
        .slot_we(we8), .dout(dout8), .dout_ok(dout_ok8), .sdram_req(sreq8),
        .sdram_addr(saddr8), .sdram_ack(ack8), .data_rdy(rdy8), .data_read(rdata8)
    );

    int          total = 0;
    int          bad   = 0;
    int          last4;
    logic [21:0] exp_addr;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  exp_we;   // zero: no grant expected
        logic [31:0] data;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last4 = 3;
    endtask

    // Reference: the first requester after the last served slot, wrapping round.
    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic expect_grant(input int g);
        check("grant_req", sreq, 1);
        check("grant_addr", saddr, a[g]);
        exp_addr = a[g];
        last4    = g;
    endtask

    // Runs one granted transaction; stale: 0 none, 1 address moves, 2 request drops.
    task automatic serve(input int g, input int ack_dly, input int data_dly,
                         input bit comb, input int stale, input logic [31:0] d);
        logic [3:0] exp_we;
        for (int i = 0; i < ack_dly; i++) begin
            rdy   = 1'($urandom_range(0, 1));
            rdata = $urandom;
            tick();
            check("ack_wait_req", sreq, 1);
            check("ack_wait_ok", dout_ok, 0);
            check("addr_hold", saddr, exp_addr);
        end
        ack = 1'b1;
        rdy = 1'b0;
        if (!comb) begin
            tick();
            ack = 1'b0;
            check("ack_drop", sreq, 0);
            check("no_early_ok", dout_ok, 0);
            for (int i = 0; i < data_dly; i++) begin
                tick();
                check("data_wait_ok", dout_ok, 0);
                check("addr_hold", saddr, exp_addr);
            end
        end
        if (stale == 1) a[g] = a[g] + 22'd4;
        else if (stale == 2) req[g] = 1'b0;
        exp_we = (req[g] && a[g] == exp_addr) ? (4'(1) << g) : 4'b0;
        rdy   = 1'b1;
        rdata = d;
        tick();
        ack = 1'b0;
        rdy = 1'b0;
        check("data_ok", dout_ok, 1);
        check("data_val", dout, d);
        check("data_we", we, exp_we);
        check("data_req_low", sreq, 0);
        tick();
        check("done_ok_clr", dout_ok, 0);
        check("done_we_clr", we, 0);
        check("done_no_grant", sreq, 0);
    endtask

    initial begin
        int cnt8 [8];
        int g;

        vecs[0] = '{4'b0001, 4'b0001, 32'h0000_0A01};
        vecs[1] = '{4'b1111, 4'b0010, 32'h0000_0A02};
        vecs[2] = '{4'b1001, 4'b1000, 32'h0000_0A03};
        vecs[3] = '{4'b1001, 4'b0001, 32'h0000_0A04};
        vecs[4] = '{4'b0100, 4'b0100, 32'h0000_0A05};
        vecs[5] = '{4'b0110, 4'b0010, 32'h0000_0A06};
        vecs[6] = '{4'b1110, 4'b0100, 32'h0000_0A07};
        vecs[7] = '{4'b0000, 4'b0000, 32'h0000_0A08};
        vecs[8] = '{4'b1000, 4'b1000, 32'h0000_0A09};
        vecs[9] = '{4'b0011, 4'b0001, 32'h0000_0A0A};

        req = '0; ack = 1'b0; rdy = 1'b0; rdata = '0;
        for (int i = 0; i < 4; i++) a[i] = '0;
        req8 = '0; ack8 = 1'b0; rdy8 = 1'b0; rdata8 = '0; addr8 = '0;
        for (int i = 0; i < 8; i++) begin
            addr8[22*i +: 22] = 22'(i * 16 + 5);
            cnt8[i] = 0;
        end
        last4 = 3;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_we", we, 0);
        check("rst_dout", dout, 0);
        check("rst_ok", dout_ok, 0);
        check("rst_req", sreq, 0);
        check("rst_addr", saddr, 0);

        // 8-slot rotation with all requests tied high, minimum turnaround
        req8 = '1;
        for (int k = 0; k < 64; k++) begin
            tick();
            check("rot_req", sreq8, 1);
            check("rot_addr", saddr8, 22'((k % 8) * 16 + 5));
            ack8 = 1'b1;
            tick();
            ack8 = 1'b0;
            rdy8 = 1'b1;
            rdata8 = 32'(k);
            tick();
            rdy8 = 1'b0;
            check("rot_ok", dout_ok8, 1);
            check("rot_we", we8, 8'(1) << (k % 8));
            for (int i = 0; i < 8; i++) if (we8[i]) cnt8[i]++;
            tick();
        end
        req8 = '0;
        for (int i = 0; i < 8; i++) check("rot_count", cnt8[i], 8);

        // Single request: slot 2
        a[2] = 22'h012345;
        req  = 4'b0100;
        tick();
        expect_grant(2);
        serve(2, 2, 1, 1'b0, 0, 32'hDEADBEEF);
        req = '0;

        // Slots 0, 1, 3 held high: served 0, 1, 3
        do_reset();
        a[0] = 22'h000111; a[1] = 22'h000222; a[3] = 22'h000333;
        req  = 4'b1011;
        tick(); expect_grant(0); serve(0, 0, 0, 1'b0, 0, 32'h1111_0000);
        tick(); expect_grant(1); serve(1, 1, 0, 1'b0, 0, 32'h1111_0001);
        tick(); expect_grant(3); serve(3, 0, 2, 1'b0, 0, 32'h1111_0003);
        req = '0;

        // Stale: slot 1 moves from 0x100 to 0x104 before data
        a[1] = 22'h000100;
        req  = 4'b0010;
        tick(); expect_grant(1); serve(1, 1, 2, 1'b0, 1, 32'h5A5A_5A5A);
        tick(); expect_grant(1);
        check("stale_regrant_addr", saddr, 22'h000104);
        serve(1, 0, 0, 1'b0, 0, 32'h5A5A_0104);
        req = '0;

        // Ack and data in the same cycle
        a[3] = 22'h00003A;
        req  = 4'b1000;
        tick(); expect_grant(3); serve(3, 1, 0, 1'b1, 0, 32'hC0FF_EE00);
        tick();
        check("comb_single_pulse", dout_ok, 0);
        req = '0;

        // Table-driven arbitration vectors from a fresh reset
        do_reset();
        for (int i = 0; i < 4; i++) a[i] = 22'(32'h1000 + i);
        for (int v = 0; v < 10; v++) begin
            req = vecs[v].req;
            tick();
            if (vecs[v].exp_we == 4'b0) begin
                check("vec_no_grant", sreq, 0);
            end else begin
                g = 0;
                for (int i = 0; i < 4; i++) if (vecs[v].exp_we[i]) g = i;
                expect_grant(g);
                serve(g, 0, 0, 1'b0, 0, vecs[v].data);
            end
        end
        req = '0;

        // Reset while waiting for data
        a[0] = 22'h000055;
        req  = 4'b0001;
        tick(); expect_grant(0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_req", sreq, 0);
        check("mid_rst_addr", saddr, 0);
        check("mid_rst_dout", dout, 0);
        check("mid_rst_ok", dout_ok, 0);
        check("mid_rst_we", we, 0);
        tick();
        rst = 1'b0;
        last4 = 3;
        req = '0;
        rdy = 1'b1;
        rdata = 32'hBAD0_BAD0;
        tick();
        rdy = 1'b0;
        check("late_data_ok", dout_ok, 0);
        check("late_data_req", sreq, 0);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) a[i] = 22'(32'h2000 + i);
        tick(); expect_grant(0); serve(0, 0, 0, 1'b0, 0, 32'h0000_2000);
        req = '0;

        // Random traffic against the rotation model
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int st;
            for (int i = 0; i < 4; i++) a[i] = 22'($urandom_range(0, 15) * 4);
            req = 4'($urandom_range(0, 15));
            tick();
            g = rr_pick(req, last4);
            if (g < 0) begin
                check("rand_no_grant", sreq, 0);
            end else begin
                expect_grant(g);
                st = $urandom_range(0, 5);
                serve(g, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 3) == 0, (st > 2) ? 0 : st, $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
